// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds port limits, index/data typedefs and the write-port priority select.
package regfile_pkg;

   localparam int MAX_RD     = 4;
   localparam int MAX_WR     = 2;
   localparam int MAX_IDX_W  = 16;
   localparam int MAX_DATA_W = 64;
   localparam int WR_PORT_W  = $clog2(MAX_WR);

   typedef logic [MAX_IDX_W-1:0]  reg_idx_t;
   typedef logic [MAX_DATA_W-1:0] reg_data_t;

   typedef struct packed {
      logic                 hit;
      logic [WR_PORT_W-1:0] port;
   } wr_hit_t;

   // Highest-numbered enabled port that targets idx wins.
   function automatic wr_hit_t wr_select(
      input logic [MAX_WR-1:0]     we,
      input reg_idx_t [MAX_WR-1:0] widx,
      input reg_idx_t              idx
   );
      wr_hit_t res;
      res = '0;
      for (int p = 0; p < MAX_WR; p++) begin
         if (we[p] && (widx[p] == idx)) begin
            res.hit  = 1'b1;
            res.port = p[WR_PORT_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy scoreboard for RAW hazard detection.
// Ports: clk, nRST, alloc_valid/alloc_index (set), clr (clear vector), rd_index -> busy.
module regfile_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int IDX_W    = 5
) (
   input  logic                         clk,
   input  logic                         nRST,
   input  logic                         alloc_valid,
   input  logic [IDX_W-1:0]             alloc_index,
   input  logic [NUM_REGS-1:0]          clr,
   input  logic [NUM_RD-1:0][IDX_W-1:0] rd_index,
   output logic [NUM_RD-1:0]            busy
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Alloc is applied after clear so a new producer wins a same-cycle race.
   always_comb begin
      busy_d = busy_q & ~clr;
      if (alloc_valid) begin
         busy_d[alloc_index] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_comb begin
      busy = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         busy[r] = busy_q[rd_index[r]];
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with write->read bypass and busy scoreboard.
// Ports: NUM_WR write ports, NUM_RD combinational read ports with busy, one alloc port.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int IDX_W   = $clog2(NUM_REGS)
) (
   input  logic                          clk,
   input  logic                          nRST,
   input  logic [NUM_WR-1:0]             reg_write,
   input  logic [NUM_WR-1:0][IDX_W-1:0]  write_index,
   input  logic [NUM_WR-1:0][DATA_W-1:0] write_data,
   input  logic [NUM_RD-1:0][IDX_W-1:0]  read_index,
   output logic [NUM_RD-1:0][DATA_W-1:0] read_data,
   output logic [NUM_RD-1:0]             read_busy,
   input  logic                          alloc_valid,
   input  logic [IDX_W-1:0]              alloc_index
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

   // Write ports padded to the package maximum so one select serves all sizes.
   logic [MAX_WR-1:0]             we_ext;
   reg_idx_t [MAX_WR-1:0]         widx_ext;
   logic [MAX_WR-1:0][DATA_W-1:0] wdata_ext;

   logic [NUM_REGS-1:0]           clr;
   logic [NUM_RD-1:0]             sb_busy;
   logic                          alloc_ok;

   wr_hit_t                       whit;
   wr_hit_t                       rhit;

   always_comb begin
      we_ext    = '0;
      widx_ext  = '0;
      wdata_ext = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         we_ext[p]    = reg_write[p] & nRST;
         widx_ext[p]  = reg_idx_t'(write_index[p]);
         wdata_ext[p] = write_data[p];
      end
   end

   always_comb begin
      regs_d = regs_q;
      clr    = '0;
      whit   = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         whit = wr_select(we_ext, widx_ext, reg_idx_t'(i));
         if (whit.hit && !((ZERO_REG != 0) && (i == 0))) begin
            regs_d[i] = wdata_ext[whit.port];
            clr[i]    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign alloc_ok = alloc_valid & nRST;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG),
      .IDX_W    (IDX_W)
   ) u_sb (
      .clk         (clk),
      .nRST        (nRST),
      .alloc_valid (alloc_ok),
      .alloc_index (alloc_index),
      .clr         (clr),
      .rd_index    (read_index),
      .busy        (sb_busy)
   );

   always_comb begin
      read_data = '0;
      read_busy = '0;
      rhit      = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         read_data[r] = regs_q[read_index[r]];
         read_busy[r] = sb_busy[r];
         if (BYPASS != 0) begin
            rhit = wr_select(we_ext, widx_ext, reg_idx_t'(read_index[r]));
            if (rhit.hit) begin
               read_data[r] = wdata_ext[rhit.port];
            end
         end
         if ((ZERO_REG != 0) && (read_index[r] == '0)) begin
            read_data[r] = '0;
            read_busy[r] = 1'b0;
         end
         if (!nRST) begin
            read_data[r] = '0;
            read_busy[r] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed scenarios then random traffic vs a model.
// Two instances share inputs: one with bypass, one without.
module tb_register_file_mp;

   logic             clk;
   logic             nrst;
   logic [1:0]       reg_write;
   logic [1:0][4:0]  write_index;
   logic [1:0][31:0] write_data;
   logic [1:0][4:0]  read_index;
   logic [1:0][31:0] rd_b;
   logic [1:0][31:0] rd_nb;
   logic [1:0]       bz_b;
   logic [1:0]       bz_nb;
   logic             alloc_valid;
   logic [4:0]       alloc_index;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_reg [32];
   bit          m_busy [32];

   register_file_mp #(.BYPASS(1)) dut (
      .clk         (clk),
      .nRST        (nrst),
      .reg_write   (reg_write),
      .write_index (write_index),
      .write_data  (write_data),
      .read_index  (read_index),
      .read_data   (rd_b),
      .read_busy   (bz_b),
      .alloc_valid (alloc_valid),
      .alloc_index (alloc_index)
   );

   register_file_mp #(.BYPASS(0)) dut_nb (
      .clk         (clk),
      .nRST        (nrst),
      .reg_write   (reg_write),
      .write_index (write_index),
      .write_data  (write_data),
      .read_index  (read_index),
      .read_data   (rd_nb),
      .read_busy   (bz_nb),
      .alloc_valid (alloc_valid),
      .alloc_index (alloc_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Expected read value from architectural state plus in-flight writes.
   function automatic logic [31:0] exp_rd(input logic [4:0] idx,
                                          input bit byp);
      logic [31:0] d;
      if (!nrst || idx == 0) return 32'h0;
      d = m_reg[idx];
      if (byp) begin
         for (int p = 0; p < 2; p++)
            if (reg_write[p] && write_index[p] == idx) d = write_data[p];
      end
      return d;
   endfunction

   function automatic logic [31:0] exp_bz(input logic [4:0] idx);
      if (!nrst || idx == 0) return 32'h0;
      return {31'h0, m_busy[idx]};
   endfunction

   task automatic model_edge();
      if (!nrst) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (reg_write[p] && write_index[p] != 0) begin
               m_reg[write_index[p]]  = write_data[p];
               m_busy[write_index[p]] = 1'b0;
            end
         end
         if (alloc_valid && alloc_index != 0) m_busy[alloc_index] = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      for (int r = 0; r < 2; r++) begin
         chk($sformatf("%s_rd%0d", tag, r), rd_b[r], exp_rd(read_index[r], 1));
         chk($sformatf("%s_nb%0d", tag, r), rd_nb[r], exp_rd(read_index[r], 0));
         chk($sformatf("%s_bz%0d", tag, r), {31'h0, bz_b[r]},
             exp_bz(read_index[r]));
         chk($sformatf("%s_bznb%0d", tag, r), {31'h0, bz_nb[r]},
             exp_bz(read_index[r]));
      end
   endtask

   // Called just after a negedge with inputs set; ends at the next negedge.
   task automatic tick(input string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      reg_write   = '0;
      write_index = '0;
      write_data  = '0;
      alloc_valid = 1'b0;
      alloc_index = '0;
   endtask

   initial begin
      nrst       = 1'b0;
      read_index = '0;
      idle();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = 32'hx;
         m_busy[i] = 1'b0;
      end
      @(negedge clk);
      tick("rst0");
      nrst = 1'b1;

      // 1: fill, then reset pulse clears everything
      for (int i = 1; i < 32; i++) begin
         reg_write      = 2'b01;
         write_index[0] = i[4:0];
         write_data[0]  = i * 3;
         alloc_valid    = 1'b1;
         alloc_index    = 5'(32 - i);
         tick("fill");
      end
      idle();
      read_index = {5'd30, 5'd10};
      #1;
      chk("fill10", rd_b[0], 32'd30);
      chk("fill30", rd_b[1], 32'd90);
      nrst = 1'b0;
      #1;
      chk("rstforce", rd_b[0], 32'h0);
      tick("rstpulse");
      nrst = 1'b1;
      for (int i = 0; i < 32; i += 2) begin
         read_index = {5'(i + 1), 5'(i)};
         #1;
         check_all("clr");
         chk("clr_d0", rd_b[0], 32'h0);
         chk("clr_d1", rd_b[1], 32'h0);
         chk("clr_b", {30'h0, bz_b}, 32'h0);
      end

      // 2: write/read/bypass
      reg_write      = 2'b01;
      write_index[0] = 5'd5;
      write_data[0]  = 32'hDEADBEEF;
      read_index     = {5'd0, 5'd5};
      #1;
      chk("byp_on", rd_b[0], 32'hDEADBEEF);
      chk("byp_off", rd_nb[0], 32'h0);
      tick("byp");
      idle();
      #1;
      chk("wr5_b", rd_b[0], 32'hDEADBEEF);
      chk("wr5_nb", rd_nb[0], 32'hDEADBEEF);

      // 3: port conflict
      reg_write   = 2'b11;
      write_index = {5'd7, 5'd7};
      write_data  = {32'h22, 32'h11};
      read_index  = {5'd7, 5'd7};
      #1;
      chk("conf_byp", rd_b[1], 32'h22);
      tick("conf");
      idle();
      #1;
      chk("conf_st", rd_nb[0], 32'h22);

      // 4: zero register
      reg_write      = 2'b01;
      write_index[0] = 5'd0;
      write_data[0]  = 32'hFFFFFFFF;
      alloc_valid    = 1'b1;
      alloc_index    = 5'd0;
      read_index     = '0;
      #1;
      chk("z_pre", rd_b[0], 32'h0);
      chk("z_preb", {31'h0, bz_b[0]}, 32'h0);
      tick("zero");
      idle();
      #1;
      chk("z_post", rd_b[0], 32'h0);
      chk("z_postb", {31'h0, bz_b[0]}, 32'h0);

      // 5: scoreboard
      read_index  = {5'd9, 5'd9};
      alloc_valid = 1'b1;
      alloc_index = 5'd9;
      tick("al9");
      idle();
      #1;
      chk("sb_set", {31'h0, bz_b[0]}, 32'h1);
      reg_write      = 2'b01;
      write_index[0] = 5'd9;
      write_data[0]  = 32'h99;
      #1;
      chk("sb_hold", {31'h0, bz_b[0]}, 32'h1);
      tick("wr9");
      idle();
      #1;
      chk("sb_clr", {31'h0, bz_b[0]}, 32'h0);
      reg_write      = 2'b10;
      write_index[1] = 5'd9;
      write_data[1]  = 32'h98;
      alloc_valid    = 1'b1;
      alloc_index    = 5'd9;
      tick("alwr9");
      idle();
      #1;
      chk("sb_race", {31'h0, bz_b[1]}, 32'h1);

      // 6: reset mid-operation
      read_index     = {5'd12, 5'd12};
      reg_write      = 2'b01;
      write_index[0] = 5'd12;
      write_data[0]  = 32'h5;
      tick("wr12");
      idle();
      alloc_valid = 1'b1;
      alloc_index = 5'd12;
      tick("al12");
      idle();
      #1;
      chk("m12_v", rd_b[0], 32'h5);
      chk("m12_b", {31'h0, bz_b[0]}, 32'h1);
      nrst           = 1'b0;
      reg_write      = 2'b01;
      write_index[0] = 5'd12;
      write_data[0]  = 32'hABCD;
      tick("rst12");
      nrst = 1'b1;
      idle();
      #1;
      chk("r12_v", rd_b[0], 32'h0);
      chk("r12_b", {31'h0, bz_b[0]}, 32'h0);

      // Random traffic, narrow index range to provoke collisions
      for (int n = 0; n < 400; n++) begin
         nrst = ($urandom_range(0, 39) != 0);
         for (int p = 0; p < 2; p++) begin
            reg_write[p]   = $urandom_range(0, 1) == 1;
            write_index[p] = 5'($urandom_range(0, 11));
            write_data[p]  = $urandom;
            read_index[p]  = 5'($urandom_range(0, 11));
         end
         alloc_valid = $urandom_range(0, 1) == 1;
         alloc_index = 5'($urandom_range(0, 11));
         tick("rnd");
      end
      idle();
      nrst = 1'b1;
      #1;
      check_all("end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
